msg_display_ctrl: RTL and testbench
===================================

// Module: msg_display_ctrl
// PURPOSE
//  Parametrised message capture and display controller for the one-time-pad datapath.
//  - Captures MSG_LEN characters from the switches, one per enable pulse.
//  - Stores the encrypted/decrypted pair for each character.
//  - Once full, drives NUM_DISP character displays: circular scrolling window, E/D bank chosen by button.
//  - Sits between the cipher core and the per-digit 7-segment encoders.
// PARAMETERS
//  CHAR_W     5    character code width; valid codes 0..CODE_MAX
//  CODE_MAX   26   highest valid code (26 = space)
//  CODE_DASH  27   code driven for "-" (blank/invalid)
//  MSG_LEN    8    characters per message (>=1)
//  NUM_DISP   4    character displays driven (>=1)
//  SCROLL_DIV 25000000  clk cycles per scroll step (>=2)
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  reset, synchronous, active-low
//  enable         in   1                  single-cycle pulse (pre-debounced): load char / restart
//  back           in   1                  single-cycle pulse: delete last loaded char
//  button         in   1                  1 = show encrypted, 0 = show decrypted (FULL state)
//  switch_val_in  in   CHAR_W             plaintext code from switches
//  encrypted_text in   CHAR_W             cipher output for switch_val_in
//  decrypted_text in   CHAR_W             decrypt output for switch_val_in
//  switch_val_out out  CHAR_W             echoed switch code, CODE_DASH if invalid/FULL
//  letter_class   out  2                  00 upper, 01 lower, 10 symbol, 11 dash
//  letter_order   out  CW=$clog2(MSG_LEN+1)  1-based index of next char; 0 in FULL
//  msg_count      out  CW                 characters stored
//  disp_out       out  NUM_DISP*CHAR_W    digit k at [k*CHAR_W +: CHAR_W], k=0 leftmost
//  led_red        out  1                  invalid switch code (LOAD only)
//  led_green      out  1                  message full
// BEHAVIOUR
//  - All outputs registered; each output reflects the inputs/state of the previous edge (1-cycle latency).
//  - Reset (rst=0): state=LOAD, count=0, scroll pos=0, divider=0; every code output=CODE_DASH.
//    Also on reset: letter_class=11, letter_order=1, LEDs=0. Stored chars are not cleared.
//  - States: LOAD, FULL.
//  - LOAD:
//    - disp_out is all CODE_DASH; letter_order=count+1; led_green=0.
//    - Invalid input (switch_val_in>CODE_MAX): led_red=1, switch_val_out=CODE_DASH, letter_class=11.
//    - Valid input: led_red=0, switch value echoed, class from table.
//    - enable with valid input: store E/D pair at index count, count++.
//      - If the new count==MSG_LEN: go to FULL, scroll pos=0, divider=0.
//    - enable with invalid input: ignored; no store, count unchanged.
//    - back with count>0: count--. back with count==0: ignored.
//    - enable and back in the same cycle: enable wins, back dropped.
//  - FULL:
//    - led_green=1, led_red=0, switch_val_out=CODE_DASH, letter_class=11, letter_order=0.
//    - Digit k shows bank[(pos+k) mod MSG_LEN], bank = button ? E : D. Button change visible next cycle.
//    - If MSG_LEN<=NUM_DISP: pos is held at 0, and digits k>=MSG_LEN show CODE_DASH.
//    - Else: divider counts 0..SCROLL_DIV-1; on the terminal count pos advances by 1.
//      - pos wraps MSG_LEN-1 -> 0.
//    - enable: go to LOAD, count=0, pos=0. back is ignored in FULL.
//  - Class table:
//    - lower: 1,3,6,7,13,14,15,16,17,19,21
//    - symbol: 12,22,23,26
//    - all other codes 0..CODE_MAX: upper
//  - Reset asserted mid-load or mid-scroll aborts immediately to the reset values above.
// CONFIGURATION
//  RED_BLINK_EN defined:
//    - led_red toggles every SCROLL_DIV cycles while the input is invalid in LOAD (shared divider).
//    - led_red is cleared at once when the input becomes valid or state changes.
//    - The divider free-runs in LOAD.
//  RED_BLINK_EN undefined: led_red is a steady level as described above.
// TESTING
//  1 Reset: rst=0 one edge -> disp_out all 27, switch_val_out=27, letter_class=11, letter_order=1, LEDs 0.
//  2 Load (MSG_LEN=4, NUM_DISP=4): codes 0,1,12,27(enable),25.
//    -> code 27 rejected with led_red=1 and count held.
//    -> after 4 valid loads led_green=1 and disp_out shows D bank.
//    -> button=1 shows E bank next cycle.
//  3 Back: load 2 chars, pulse back -> count=1 and letter_order=2.
//    -> then back+enable same cycle with code 5: count=2, slot 1 holds code 5's pair.
//  4 Scroll (MSG_LEN=6, NUM_DISP=4, SCROLL_DIV=4): D bank = d0..d5.
//    -> window d0-d3, then after 4 cycles d1-d4, and so on.
//    -> window d5,d0,d1,d2 at pos=5; wrap back to d0-d3.
//  5 Short message (MSG_LEN=2, NUM_DISP=4): digits 2,3 = 27 and never scroll.
//    -> enable in FULL returns to LOAD with count=0.
//  6 RED_BLINK_EN build, SCROLL_DIV=4: hold code 30 -> led_red toggles every 4 cycles.
//    -> switch to code 3 -> led_red=0 next cycle.

Source files
------------

// File: rtl/msg_display_ctrl.sv
// Message capture and scrolling display controller for the one-time-pad datapath.
// Define RED_BLINK_EN to make led_red blink on invalid input instead of holding steady.
module msg_display_ctrl #(
  parameter int unsigned CHAR_W     = 5,
  parameter int unsigned CODE_MAX   = 26,
  parameter int unsigned CODE_DASH  = 27,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned NUM_DISP   = 4,
  parameter int unsigned SCROLL_DIV = 25000000,
  localparam int unsigned CW        = $clog2(MSG_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         back,
  input  logic                         button,
  input  logic [CHAR_W-1:0]            switch_val_in,
  input  logic [CHAR_W-1:0]            encrypted_text,
  input  logic [CHAR_W-1:0]            decrypted_text,
  output logic [CHAR_W-1:0]            switch_val_out,
  output logic [1:0]                   letter_class,
  output logic [CW-1:0]                letter_order,
  output logic [CW-1:0]                msg_count,
  output logic [NUM_DISP*CHAR_W-1:0]   disp_out,
  output logic                         led_red,
  output logic                         led_green
);

  localparam int unsigned IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned DW = $clog2(SCROLL_DIV);
  localparam logic [CHAR_W-1:0] Dash = CHAR_W'(CODE_DASH);

  typedef enum logic {StLoad, StFull} state_e;

  state_e                      state_q;
  logic [CW-1:0]               count_q;
  logic [IW-1:0]               pos_q;
  logic [DW-1:0]               div_q;
  logic [CHAR_W-1:0]           enc_q [MSG_LEN];
  logic [CHAR_W-1:0]           dec_q [MSG_LEN];
  logic [CHAR_W-1:0]           sw_out_q;
  logic [1:0]                  class_q;
  logic [CW-1:0]               order_q;
  logic [CW-1:0]               msg_count_q;
  logic [NUM_DISP*CHAR_W-1:0]  disp_q;
  logic                        led_red_q;
  logic                        led_green_q;
`ifdef RED_BLINK_EN
  logic                        red_act_q;
`endif

  logic                        sw_valid;
  logic                        div_term;
  logic [NUM_DISP*CHAR_W-1:0]  disp_win;

  function automatic logic [1:0] class_of(logic [CHAR_W-1:0] code);
    case (32'(code))
      1, 3, 6, 7, 13, 14, 15, 16, 17, 19, 21: return 2'b01;
      12, 22, 23, 26:                         return 2'b10;
      default:                                return 2'b00;
    endcase
  endfunction

  // (pos + k) mod MSG_LEN; one subtraction suffices because pos < MSG_LEN when scrolling.
  function automatic logic [IW-1:0] win_idx(logic [IW-1:0] pos, int unsigned k);
    int unsigned sum;
    sum = 32'(pos) + k;
    if (sum >= MSG_LEN) sum -= MSG_LEN;
    return IW'(sum);
  endfunction

  always_comb begin
    sw_valid = (switch_val_in <= CHAR_W'(CODE_MAX));
    div_term = (div_q == DW'(SCROLL_DIV - 1));
    disp_win = '0;
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      if (k >= MSG_LEN) begin
        disp_win[k*CHAR_W +: CHAR_W] = Dash;
      end else if (button) begin
        disp_win[k*CHAR_W +: CHAR_W] = enc_q[win_idx(pos_q, k)];
      end else begin
        disp_win[k*CHAR_W +: CHAR_W] = dec_q[win_idx(pos_q, k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StLoad;
      count_q     <= '0;
      pos_q       <= '0;
      div_q       <= '0;
      sw_out_q    <= Dash;
      class_q     <= 2'b11;
      order_q     <= CW'(1);
      msg_count_q <= '0;
      disp_q      <= {NUM_DISP{Dash}};
      led_red_q   <= 1'b0;
      led_green_q <= 1'b0;
`ifdef RED_BLINK_EN
      red_act_q   <= 1'b0;
`endif
    end else begin
      msg_count_q <= count_q;
      case (state_q)
        StLoad: begin
          disp_q      <= {NUM_DISP{Dash}};
          order_q     <= count_q + 1'b1;
          led_green_q <= 1'b0;
          sw_out_q    <= sw_valid ? switch_val_in : Dash;
          class_q     <= sw_valid ? class_of(switch_val_in) : 2'b11;
`ifdef RED_BLINK_EN
          div_q     <= div_term ? '0 : div_q + 1'b1;
          red_act_q <= !sw_valid;
          if (sw_valid)        led_red_q <= 1'b0;
          else if (!red_act_q) led_red_q <= 1'b1;
          else if (div_term)   led_red_q <= !led_red_q;
`else
          div_q     <= '0;
          led_red_q <= !sw_valid;
`endif
          // enable takes priority; a simultaneous back is dropped
          if (enable) begin
            if (sw_valid) begin
              enc_q[IW'(count_q)] <= encrypted_text;
              dec_q[IW'(count_q)] <= decrypted_text;
              count_q             <= count_q + 1'b1;
              if (count_q == CW'(MSG_LEN - 1)) begin
                state_q <= StFull;
                pos_q   <= '0;
                div_q   <= '0;
              end
            end
          end else if (back && count_q != '0) begin
            count_q <= count_q - 1'b1;
          end
        end
        StFull: begin
          led_green_q <= 1'b1;
          led_red_q   <= 1'b0;
          sw_out_q    <= Dash;
          class_q     <= 2'b11;
          order_q     <= '0;
          disp_q      <= disp_win;
`ifdef RED_BLINK_EN
          red_act_q   <= 1'b0;
`endif
          if (enable) begin
            state_q <= StLoad;
            count_q <= '0;
            pos_q   <= '0;
            div_q   <= '0;
          end else if (MSG_LEN > NUM_DISP) begin
            if (div_term) begin
              div_q <= '0;
              pos_q <= (pos_q == IW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign switch_val_out = sw_out_q;
  assign letter_class   = class_q;
  assign letter_order   = order_q;
  assign msg_count      = msg_count_q;
  assign disp_out       = disp_q;
  assign led_red        = led_red_q;
  assign led_green      = led_green_q;

endmodule

// File: tb/tb_msg_display_ctrl.sv
// Directed bench for msg_display_ctrl: three instances cover full-width, scrolling and
// short-message configurations; the blink test runs only when RED_BLINK_EN is defined.
module tb_msg_display_ctrl;
  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] sw = '0, enc = '0, dec = '0;
  logic button = 1'b0;
  logic en_a = 1'b0, bk_a = 1'b0, en_b = 1'b0, bk_b = 1'b0, en_c = 1'b0, bk_c = 1'b0;

  logic [W-1:0]   a_sw, b_sw, c_sw;
  logic [1:0]     a_cls, b_cls, c_cls;
  logic [2:0]     a_ord, a_cnt, b_ord, b_cnt;
  logic [1:0]     c_ord, c_cnt;
  logic [4*W-1:0] a_disp, b_disp, c_disp;
  logic           a_red, a_grn, b_red, b_grn, c_red, c_grn;

  int checks = 0;
  int errors = 0;

  localparam logic [4*W-1:0] AllDash = {4{5'd27}};

  msg_display_ctrl #(.CHAR_W(5), .CODE_MAX(26), .CODE_DASH(27), .MSG_LEN(4), .NUM_DISP(4),
                     .SCROLL_DIV(4)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .back(bk_a), .button(button), .switch_val_in(sw),
    .encrypted_text(enc), .decrypted_text(dec), .switch_val_out(a_sw), .letter_class(a_cls),
    .letter_order(a_ord), .msg_count(a_cnt), .disp_out(a_disp), .led_red(a_red),
    .led_green(a_grn)
  );

  msg_display_ctrl #(.CHAR_W(5), .CODE_MAX(26), .CODE_DASH(27), .MSG_LEN(6), .NUM_DISP(4),
                     .SCROLL_DIV(4)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .back(bk_b), .button(button), .switch_val_in(sw),
    .encrypted_text(enc), .decrypted_text(dec), .switch_val_out(b_sw), .letter_class(b_cls),
    .letter_order(b_ord), .msg_count(b_cnt), .disp_out(b_disp), .led_red(b_red),
    .led_green(b_grn)
  );

  msg_display_ctrl #(.CHAR_W(5), .CODE_MAX(26), .CODE_DASH(27), .MSG_LEN(2), .NUM_DISP(4),
                     .SCROLL_DIV(4)) u_c (
    .clk(clk), .rst(rst), .enable(en_c), .back(bk_c), .button(button), .switch_val_in(sw),
    .encrypted_text(enc), .decrypted_text(dec), .switch_val_out(c_sw), .letter_class(c_cls),
    .letter_order(c_ord), .msg_count(c_cnt), .disp_out(c_disp), .led_red(c_red),
    .led_green(c_grn)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    checks++; if (a_disp !== AllDash) begin errors++; $display("FAIL rst_disp got %h want %h", a_disp, AllDash); end
    checks++; if (a_sw !== 5'd27) begin errors++; $display("FAIL rst_sw got %0d want 27", a_sw); end
    checks++; if (a_cls !== 2'b11) begin errors++; $display("FAIL rst_class got %b want 11", a_cls); end
    checks++; if (a_ord !== 3'd1) begin errors++; $display("FAIL rst_order got %0d want 1", a_ord); end
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", a_cnt); end
    checks++; if ({a_red, a_grn} !== 2'b00) begin errors++; $display("FAIL rst_leds got %b want 00", {a_red, a_grn}); end
    checks++; if (c_disp !== AllDash) begin errors++; $display("FAIL rst_disp_c got %h want %h", c_disp, AllDash); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load;
    sw = 5'd0; enc = 5'd10; dec = 5'd20; en_a = 1'b1;
    tick();
    checks++; if (a_sw !== 5'd0 || a_cls !== 2'b00) begin errors++; $display("FAIL load0 got sw %0d cls %b want 0 00", a_sw, a_cls); end
    checks++; if (a_ord !== 3'd1) begin errors++; $display("FAIL load0_order got %0d want 1", a_ord); end
    sw = 5'd1; enc = 5'd11; dec = 5'd21;
    tick();
    checks++; if (a_cls !== 2'b01 || a_ord !== 3'd2) begin errors++; $display("FAIL load1 got cls %b ord %0d want 01 2", a_cls, a_ord); end
    sw = 5'd12; enc = 5'd12; dec = 5'd22;
    tick();
    checks++; if (a_cls !== 2'b10 || a_cnt !== 3'd2) begin errors++; $display("FAIL load12 got cls %b cnt %0d want 10 2", a_cls, a_cnt); end
    sw = 5'd27;
    tick();
    checks++; if (a_red !== 1'b1 || a_sw !== 5'd27 || a_cls !== 2'b11) begin errors++; $display("FAIL load_inv got red %b sw %0d cls %b want 1 27 11", a_red, a_sw, a_cls); end
    sw = 5'd25; enc = 5'd15; dec = 5'd25; en_a = 1'b0;
    tick();
    checks++; if (a_red !== 1'b0 || a_cls !== 2'b00) begin errors++; $display("FAIL load25 got red %b cls %b want 0 00", a_red, a_cls); end
    checks++; if (a_cnt !== 3'd3 || a_ord !== 3'd4) begin errors++; $display("FAIL load_held got cnt %0d ord %0d want 3 4", a_cnt, a_ord); end
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    checks++; if (a_grn !== 1'b0) begin errors++; $display("FAIL load_last_grn got %b want 0", a_grn); end
    tick();
    checks++; if (a_grn !== 1'b1 || a_red !== 1'b0) begin errors++; $display("FAIL full_leds got %b%b want 10", a_grn, a_red); end
    checks++; if (a_ord !== 3'd0 || a_sw !== 5'd27 || a_cls !== 2'b11) begin errors++; $display("FAIL full_outs got ord %0d sw %0d cls %b want 0 27 11", a_ord, a_sw, a_cls); end
    checks++; if (a_disp !== {5'd25, 5'd22, 5'd21, 5'd20}) begin errors++; $display("FAIL full_dbank got %h want %h", a_disp, {5'd25, 5'd22, 5'd21, 5'd20}); end
    button = 1'b1;
    tick();
    checks++; if (a_disp !== {5'd15, 5'd12, 5'd11, 5'd10}) begin errors++; $display("FAIL full_ebank got %h want %h", a_disp, {5'd15, 5'd12, 5'd11, 5'd10}); end
  endtask

  task automatic test_back;
    button = 1'b0; en_a = 1'b1;
    tick();
    en_a = 1'b0; bk_a = 1'b1;
    tick();
    bk_a = 1'b0;
    tick();
    checks++; if (a_cnt !== 3'd0 || a_ord !== 3'd1) begin errors++; $display("FAIL back_at0 got cnt %0d ord %0d want 0 1", a_cnt, a_ord); end
    sw = 5'd2; enc = 5'd3; dec = 5'd4; en_a = 1'b1;
    tick();
    sw = 5'd3; enc = 5'd5; dec = 5'd6;
    tick();
    en_a = 1'b0; bk_a = 1'b1;
    tick();
    bk_a = 1'b0;
    tick();
    checks++; if (a_cnt !== 3'd1 || a_ord !== 3'd2) begin errors++; $display("FAIL back got cnt %0d ord %0d want 1 2", a_cnt, a_ord); end
    sw = 5'd5; enc = 5'd7; dec = 5'd8; en_a = 1'b1; bk_a = 1'b1;
    tick();
    en_a = 1'b0; bk_a = 1'b0;
    tick();
    checks++; if (a_cnt !== 3'd2 || a_ord !== 3'd3) begin errors++; $display("FAIL back_en got cnt %0d ord %0d want 2 3", a_cnt, a_ord); end
    sw = 5'd6; enc = 5'd9; dec = 5'd10; en_a = 1'b1;
    tick();
    sw = 5'd7; enc = 5'd11; dec = 5'd12;
    tick();
    en_a = 1'b0;
    tick();
    checks++; if (a_disp !== {5'd12, 5'd10, 5'd8, 5'd4}) begin errors++; $display("FAIL back_dbank got %h want %h", a_disp, {5'd12, 5'd10, 5'd8, 5'd4}); end
    button = 1'b1;
    tick();
    checks++; if (a_disp !== {5'd11, 5'd9, 5'd7, 5'd3}) begin errors++; $display("FAIL back_ebank got %h want %h", a_disp, {5'd11, 5'd9, 5'd7, 5'd3}); end
    button = 1'b0;
  endtask

  task automatic test_scroll;
    logic [4*W-1:0] exp;
    int p;
    button = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sw = W'(k); enc = W'(k + 10); dec = W'(k + 20); en_b = 1'b1;
      tick();
    end
    en_b = 1'b0;
    for (int s = 1; s <= 28; s++) begin
      tick();
      p = ((s - 1) / 4) % 6;
      for (int k = 0; k < 4; k++) exp[k*W +: W] = W'(20 + (p + k) % 6);
      checks++; if (b_disp !== exp) begin errors++; $display("FAIL scroll s=%0d got %h want %h", s, b_disp, exp); end
    end
    checks++; if (b_grn !== 1'b1) begin errors++; $display("FAIL scroll_grn got %b want 1", b_grn); end
  endtask

  task automatic test_short;
    sw = 5'd4; enc = 5'd1; dec = 5'd2; en_c = 1'b1;
    tick();
    sw = 5'd5; enc = 5'd3; dec = 5'd4;
    tick();
    en_c = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
      checks++; if (c_disp !== {5'd27, 5'd27, 5'd4, 5'd2}) begin errors++; $display("FAIL short s=%0d got %h want %h", s, c_disp, {5'd27, 5'd27, 5'd4, 5'd2}); end
    end
    checks++; if (c_ord !== 2'd0 || c_grn !== 1'b1) begin errors++; $display("FAIL short_full got ord %0d grn %b want 0 1", c_ord, c_grn); end
    en_c = 1'b1;
    tick();
    en_c = 1'b0;
    tick();
    checks++; if (c_cnt !== 2'd0 || c_ord !== 2'd1 || c_grn !== 1'b0) begin errors++; $display("FAIL short_restart got cnt %0d ord %0d grn %b want 0 1 0", c_cnt, c_ord, c_grn); end
    checks++; if (c_disp !== AllDash) begin errors++; $display("FAIL short_restart_disp got %h want %h", c_disp, AllDash); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b0;
    tick();
    checks++; if (b_disp !== AllDash || b_grn !== 1'b0) begin errors++; $display("FAIL rstmid got disp %h grn %b want %h 0", b_disp, b_grn, AllDash); end
    checks++; if (b_cnt !== 3'd0 || b_ord !== 3'd1) begin errors++; $display("FAIL rstmid_cnt got cnt %0d ord %0d want 0 1", b_cnt, b_ord); end
    rst = 1'b1;
    tick();
    tick();
    checks++; if (b_grn !== 1'b0 || b_disp !== AllDash) begin errors++; $display("FAIL rstmid_after got grn %b disp %h want 0 %h", b_grn, b_disp, AllDash); end
  endtask

`ifdef RED_BLINK_EN
  task automatic test_red_blink;
    int n;
    sw = 5'd30;
    tick();
    checks++; if (a_red !== 1'b1) begin errors++; $display("FAIL blink_on got %b want 1", a_red); end
    n = 0;
    while (a_red === 1'b1 && n < 5) begin
      tick();
      n++;
    end
    checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL blink_first_toggle got %b want 0 within 5", a_red); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL blink_low i=%0d got %b want 0", i, a_red); end
    end
    tick();
    checks++; if (a_red !== 1'b1) begin errors++; $display("FAIL blink_period got %b want 1", a_red); end
    sw = 5'd3;
    tick();
    checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL blink_clear got %b want 0", a_red); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back();
    test_scroll();
    test_short();
    test_reset_mid();
`ifdef RED_BLINK_EN
    test_red_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
